simon_pipe_core: RTL and testbench



---
 rtl/simon_pkg.sv | 63 ++++++
 rtl/simon_key_expand.sv | 91 +++++++++
 rtl/simon_pipe_core.sv | 132 +++++++++++++
 tb/tb_simon_pipe_core.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared Simon definitions: z-sequences, word-rotation helpers, round function and enums.
package simon_pkg;

  localparam int unsigned MAX_W = 64;
  localparam int unsigned Z_LEN = 62;
  localparam int unsigned ZI_W  = $clog2(Z_LEN);

  typedef enum logic {
    ENC = 1'b0,
    DEC = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    KEY_EMPTY  = 2'd0,
    KEY_EXPAND = 2'd1,
    KEY_READY  = 2'd2
  } key_state_e;

  // Sequences are written first-element-first; reversal puts element 0 at bit 0.
  function automatic logic [Z_LEN-1:0] rev_z(input logic [Z_LEN-1:0] v);
    logic [Z_LEN-1:0] r;
    r = '0;
    for (int i = 0; i < int'(Z_LEN); i++) r[i] = v[int'(Z_LEN) - 1 - i];
    return r;
  endfunction

  localparam logic [Z_LEN-1:0] Z0 = rev_z(62'b11111010001001010110000111001101111101000100101011000011100110);
  localparam logic [Z_LEN-1:0] Z1 = rev_z(62'b10001110111110010011000010110101000111011111001001100001011010);
  localparam logic [Z_LEN-1:0] Z2 = rev_z(62'b10101111011100000011010010011000101000010001111110010110110011);
  localparam logic [Z_LEN-1:0] Z3 = rev_z(62'b11011011101011000110010111100000010010001010011100110100001111);
  localparam logic [Z_LEN-1:0] Z4 = rev_z(62'b11010001111001101011011000100000010111000011001010010011101111);

  function automatic logic [Z_LEN-1:0] z_sel(input int unsigned idx);
    case (idx)
      0:       return Z0;
      1:       return Z1;
      2:       return Z2;
      3:       return Z3;
      default: return Z4;
    endcase
  endfunction

  function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
    return (MAX_W'(1) << w) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] rol(input logic [MAX_W-1:0] x, input int unsigned s,
                                           input int unsigned w);
    logic [MAX_W-1:0] v;
    v = x & width_mask(w);
    return ((v << s) | (v >> (w - s))) & width_mask(w);
  endfunction

  function automatic logic [MAX_W-1:0] ror(input logic [MAX_W-1:0] x, input int unsigned s,
                                           input int unsigned w);
    return rol(x, w - s, w);
  endfunction

  function automatic logic [MAX_W-1:0] simon_f(input logic [MAX_W-1:0] x, input int unsigned w);
    return (rol(x, 1, w) & rol(x, 8, w)) ^ rol(x, 2, w);
  endfunction

endpackage

// File: rtl/simon_key_expand.sv
// Round-key expansion: loads the master key, then derives one round key per cycle.
module simon_key_expand
  import simon_pkg::*;
#(
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned KEY_WORDS = 4,
  parameter int unsigned ROUNDS    = 32,
  parameter int unsigned Z_IDX     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [KEY_WORDS*WORD_W-1:0]   key_in,
  input  logic                          key_load,
  input  logic                          pipe_busy,
  output logic                          key_ready_c,
  output logic                          key_valid,
  output logic [ROUNDS*WORD_W-1:0]      rk
);

  localparam int unsigned IDX_W = $clog2(ROUNDS);
  localparam logic [Z_LEN-1:0]  ZSEQ     = z_sel(Z_IDX);
  localparam logic [WORD_W-1:0] RK_CONST = ~WORD_W'(3);

  key_state_e        state;
  key_state_e        state_nxt;
  logic              load_acc;
  logic              gen_en;
  logic [IDX_W-1:0]  idx;
  logic [ZI_W-1:0]   zi;
  logic [WORD_W-1:0] rk_q [ROUNDS];
  logic [WORD_W-1:0] tmp;
  logic [WORD_W-1:0] rk_new;

  always_ff @(posedge clk) begin
    if (!rst) state <= KEY_EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      KEY_EMPTY, KEY_READY: if (load_acc) state_nxt = KEY_EXPAND;
      KEY_EXPAND:           if (idx == IDX_W'(ROUNDS - 1)) state_nxt = KEY_READY;
      default:              state_nxt = KEY_EMPTY;
    endcase
  end

  // Keys may only change with nothing in flight, so loads wait for an empty pipe.
  always_comb begin
    key_ready_c = (state != KEY_EXPAND) && !pipe_busy;
    load_acc    = key_load && key_ready_c;
    gen_en      = (state == KEY_EXPAND);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_valid <= 1'b0;
      idx       <= '0;
      zi        <= '0;
    end else begin
      key_valid <= (state_nxt == KEY_READY);
      if (load_acc) begin
        idx <= IDX_W'(KEY_WORDS);
        zi  <= '0;
      end else if (gen_en) begin
        idx <= idx + IDX_W'(1);
        zi  <= (zi == ZI_W'(Z_LEN - 1)) ? '0 : zi + ZI_W'(1);
      end
    end
  end

  always_comb begin
    tmp = WORD_W'(ror(MAX_W'(rk_q[idx - IDX_W'(1)]), 3, WORD_W));
    if (KEY_WORDS == 4) tmp = tmp ^ rk_q[idx - IDX_W'(3)];
    tmp    = tmp ^ WORD_W'(ror(MAX_W'(tmp), 1, WORD_W));
    rk_new = rk_q[idx - IDX_W'(KEY_WORDS)] ^ tmp ^ RK_CONST ^ WORD_W'(ZSEQ[zi]);
  end

  always_ff @(posedge clk) begin
    if (load_acc) begin
      for (int j = 0; j < int'(KEY_WORDS); j++) rk_q[j] <= key_in[j*WORD_W +: WORD_W];
    end else if (gen_en) begin
      rk_q[idx] <= rk_new;
    end
  end

  for (genvar j = 0; j < int'(ROUNDS); j++) begin : g_rk_out
    assign rk[j*WORD_W +: WORD_W] = rk_q[j];
  end

endmodule

// File: rtl/simon_pipe_core.sv
// Fully unrolled Simon pipeline, one round per stage, with valid/ready back-pressure.
// Optional SIMON_TAG_EN adds in_tag/out_tag carried alongside each block.
module simon_pipe_core
  import simon_pkg::*;
#(
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned KEY_WORDS = 4,
  parameter int unsigned ROUNDS    = 32,
  parameter int unsigned Z_IDX     = 0
`ifdef SIMON_TAG_EN
  ,
  parameter int unsigned TAG_W     = 8
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [KEY_WORDS*WORD_W-1:0] key_in,
  input  logic                        key_load,
  output logic                        key_ready,
  output logic                        key_valid,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_mode,
`ifdef SIMON_TAG_EN
  input  logic [TAG_W-1:0]            in_tag,
  output logic [TAG_W-1:0]            out_tag,
`endif
  input  logic [2*WORD_W-1:0]         in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_mode,
  output logic [2*WORD_W-1:0]         out_data
);

  localparam int unsigned BLK_W = 2 * WORD_W;
  localparam int unsigned LAST  = ROUNDS - 1;

  logic                     advance;
  logic                     fire;
  logic                     pipe_busy;
  logic [ROUNDS*WORD_W-1:0] rk;
  logic [BLK_W-1:0]         in_swapped;
  logic [BLK_W-1:0]         rnd      [ROUNDS];
  logic [BLK_W-1:0]         st_data  [LAST];
  logic [LAST-1:0]          st_valid;
  logic [LAST-1:0]          st_mode;
`ifdef SIMON_TAG_EN
  logic [TAG_W-1:0]         st_tag   [LAST];
`endif

  function automatic logic [BLK_W-1:0] swap_halves(input logic [BLK_W-1:0] v);
    return {v[WORD_W-1:0], v[BLK_W-1:WORD_W]};
  endfunction

  simon_key_expand #(
    .WORD_W    (WORD_W),
    .KEY_WORDS (KEY_WORDS),
    .ROUNDS    (ROUNDS),
    .Z_IDX     (Z_IDX)
  ) u_key (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_load    (key_load),
    .pipe_busy   (pipe_busy),
    .key_ready_c (key_ready),
    .key_valid   (key_valid),
    .rk          (rk)
  );

  assign advance    = !out_valid || out_ready;
  assign in_ready   = key_valid && advance;
  assign fire       = in_valid && in_ready;
  assign pipe_busy  = (|st_valid) || out_valid;
  assign in_swapped = (mode_e'(in_mode) == DEC) ? swap_halves(in_data) : in_data;

  // Decrypt reuses the encrypt round on swapped halves with the key order reversed.
  for (genvar s = 0; s < int'(ROUNDS); s++) begin : g_round
    logic [BLK_W-1:0]  src;
    logic              md;
    logic [WORD_W-1:0] rkey;
    if (s == 0) begin : g_first
      assign src = in_swapped;
      assign md  = in_mode;
    end else begin : g_next
      assign src = st_data[s-1];
      assign md  = st_mode[s-1];
    end
    assign rkey   = (mode_e'(md) == DEC) ? rk[(ROUNDS-1-s)*WORD_W +: WORD_W]
                                         : rk[s*WORD_W +: WORD_W];
    assign rnd[s] = {src[WORD_W-1:0] ^ rkey ^
                     WORD_W'(simon_f(MAX_W'(src[BLK_W-1:WORD_W]), WORD_W)),
                     src[BLK_W-1:WORD_W]};
  end

  // Control bits and the output stage; the final stage holds results already un-swapped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_valid  <= '0;
      st_mode   <= '0;
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_data  <= '0;
`ifdef SIMON_TAG_EN
      for (int s = 0; s < int'(LAST); s++) st_tag[s] <= '0;
      out_tag   <= '0;
`endif
    end else if (advance) begin
      st_valid[0] <= fire;
      st_mode[0]  <= in_mode;
      for (int s = 1; s < int'(LAST); s++) begin
        st_valid[s] <= st_valid[s-1];
        st_mode[s]  <= st_mode[s-1];
      end
      out_valid <= st_valid[LAST-1];
      out_mode  <= st_mode[LAST-1];
      out_data  <= (mode_e'(st_mode[LAST-1]) == DEC) ? swap_halves(rnd[LAST]) : rnd[LAST];
`ifdef SIMON_TAG_EN
      st_tag[0] <= in_tag;
      for (int s = 1; s < int'(LAST); s++) st_tag[s] <= st_tag[s-1];
      out_tag   <= st_tag[LAST-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      for (int s = 0; s < int'(LAST); s++) st_data[s] <= rnd[s];
    end
  end

endmodule

// File: tb/tb_simon_pipe_core.sv
// Directed bench for simon_pipe_core: Simon32/64 and Simon64/128 vectors, handshake and key control.
module tb_simon_pipe_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [63:0] key_in    = 64'h1918_1110_0908_0100;
  logic        key_load  = 1'b0;
  logic        key_ready;
  logic        key_valid;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic        in_mode   = 1'b0;
  logic [31:0] in_data   = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_mode;
  logic [31:0] out_data;

  logic [127:0] w_key_in   = 128'h1b1a1918_13121110_0b0a0908_03020100;
  logic         w_key_load = 1'b0;
  logic         w_key_ready;
  logic         w_key_valid;
  logic         w_in_valid = 1'b0;
  logic         w_in_ready;
  logic         w_in_mode  = 1'b0;
  logic [63:0]  w_in_data  = '0;
  logic         w_out_valid;
  logic         w_out_ready = 1'b1;
  logic         w_out_mode;
  logic [63:0]  w_out_data;

`ifdef SIMON_TAG_EN
  logic [7:0] in_tag = '0;
  logic [7:0] out_tag;
  logic [7:0] w_in_tag = '0;
  logic [7:0] w_out_tag;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  simon_pipe_core dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_load  (key_load),
    .key_ready (key_ready),
    .key_valid (key_valid),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
`ifdef SIMON_TAG_EN
    .in_tag    (in_tag),
    .out_tag   (out_tag),
`endif
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_data  (out_data)
  );

  simon_pipe_core #(
    .WORD_W    (32),
    .KEY_WORDS (4),
    .ROUNDS    (44),
    .Z_IDX     (3)
  ) dut_wide (
    .clk       (clk),
    .rst       (rst),
    .key_in    (w_key_in),
    .key_load  (w_key_load),
    .key_ready (w_key_ready),
    .key_valid (w_key_valid),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_mode   (w_in_mode),
`ifdef SIMON_TAG_EN
    .in_tag    (w_in_tag),
    .out_tag   (w_out_tag),
`endif
    .in_data   (w_in_data),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .out_mode  (w_out_mode),
    .out_data  (w_out_data)
  );

  // Sends one block into the main core and waits for its result (out_ready held high).
  task automatic run_block(input logic mode, input logic [31:0] data, output logic acc,
                           output int lat, output logic [31:0] res, output logic res_mode);
    @(negedge clk);
    in_valid = 1'b1; in_mode = mode; in_data = data;
    #1 acc = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = out_data; res_mode = out_mode;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL reset_key_ready got=%b want=1", key_ready); end
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid got=%b want=0", key_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    n_checks++; if (out_mode !== 1'b0) begin n_fail++; $display("FAIL reset_out_mode got=%b want=0", out_mode); end
    n_checks++; if (w_key_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wide_key_ready got=%b want=1", w_key_ready); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_key_expand();
    int e;
    key_in = 64'h1918_1110_0908_0100;
    key_load = 1'b1;
    #1;
    n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL key_ready_empty got=%b want=1", key_ready); end
    @(negedge clk);
    key_load = 1'b0;
    e = 0;
    while (!key_valid && e < 200) begin
      @(negedge clk);
      e++;
    end
    n_checks++; if (e != 28) begin n_fail++; $display("FAIL key_expand_cycles got=%0d want=28", e); end
  endtask

  task automatic test_encrypt();
    logic acc, rmode; int lat; logic [31:0] res;
    run_block(1'b0, 32'h6565_6877, acc, lat, res, rmode);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL enc_in_ready got=%b want=1", acc); end
    n_checks++; if (lat != 31) begin n_fail++; $display("FAIL enc_latency got=%0d want=31", lat); end
    n_checks++; if (res !== 32'hc69b_e9bb) begin n_fail++; $display("FAIL enc_data got=%h want=c69be9bb", res); end
    n_checks++; if (rmode !== 1'b0) begin n_fail++; $display("FAIL enc_mode got=%b want=0", rmode); end
  endtask

  task automatic test_decrypt();
    logic acc, rmode; int lat; logic [31:0] res;
    run_block(1'b1, 32'hc69b_e9bb, acc, lat, res, rmode);
    n_checks++; if (lat != 31) begin n_fail++; $display("FAIL dec_latency got=%0d want=31", lat); end
    n_checks++; if (res !== 32'h6565_6877) begin n_fail++; $display("FAIL dec_data got=%h want=65656877", res); end
    n_checks++; if (rmode !== 1'b1) begin n_fail++; $display("FAIL dec_mode got=%b want=1", rmode); end
  endtask

  // Even blocks encrypt, odd blocks decrypt, so each result's value and mode reveal its position.
  task automatic test_back_to_back();
    int tx, rx, cyc, extra;
    logic stalled;
    logic [31:0] held;
    logic [31:0] exp_d;
    tx = 0; rx = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (rx < 40 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          n_fail++;
          $display("FAIL b2b_stall_hold got=%b/%h want=1/%h", out_valid, out_data, held);
        end
      end
      in_valid  = (tx < 40);
      in_mode   = tx[0];
      in_data   = tx[0] ? 32'hc69b_e9bb : 32'h6565_6877;
      out_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (out_valid && out_ready) begin
        exp_d = rx[0] ? 32'h6565_6877 : 32'hc69b_e9bb;
        n_checks++;
        if (out_data !== exp_d || out_mode !== rx[0]) begin
          n_fail++;
          $display("FAIL b2b_result idx=%0d got=%h/%b want=%h/%b", rx, out_data, out_mode, exp_d, rx[0]);
        end
        rx++;
      end
      if (in_valid && in_ready) tx++;
      stalled = out_valid && !out_ready;
      held    = out_data;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (rx != 40) begin n_fail++; $display("FAIL b2b_count got=%0d want=40", rx); end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL b2b_extra got=%0d want=0", extra); end
  endtask

  task automatic test_key_lock();
    int e, bad;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_mode = 1'b0; in_data = 32'h6565_6877;
    @(negedge clk);
    in_valid = 1'b0;
    key_in = 64'hdead_beef_0123_4567;
    key_load = 1'b1;
    #1;
    n_checks++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL lock_key_ready got=%b want=0", key_ready); end
    @(negedge clk);
    key_load = 1'b0;
    n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL lock_key_valid got=%b want=1", key_valid); end
    e = 0;
    while (!out_valid && e < 200) begin
      @(negedge clk);
      e++;
    end
    n_checks++; if (out_data !== 32'hc69b_e9bb) begin n_fail++; $display("FAIL lock_data got=%h want=c69be9bb", out_data); end
    @(negedge clk);
    key_in = 64'h1918_1110_0908_0100;
    key_load = 1'b1;
    #1;
    n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL drain_key_ready got=%b want=1", key_ready); end
    @(negedge clk);
    key_load = 1'b0;
    e = 0; bad = 0;
    while (!key_valid && e < 200) begin
      if (in_ready) bad++;
      @(negedge clk);
      e++;
    end
    n_checks++; if (e != 28) begin n_fail++; $display("FAIL reload_cycles got=%0d want=28", e); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL reload_in_ready got=%0d want=0", bad); end
  endtask

  task automatic test_wide();
    int e;
    @(negedge clk);
    w_key_load = 1'b1;
    @(negedge clk);
    w_key_load = 1'b0;
    e = 0;
    while (!w_key_valid && e < 200) begin
      @(negedge clk);
      e++;
    end
    n_checks++; if (e != 40) begin n_fail++; $display("FAIL wide_expand_cycles got=%0d want=40", e); end
    w_in_valid = 1'b1; w_in_mode = 1'b0; w_in_data = 64'h656b696c_20646e75;
    @(negedge clk);
    w_in_valid = 1'b0;
    e = 0;
    while (!w_out_valid && e < 200) begin
      @(negedge clk);
      e++;
    end
    n_checks++; if (e != 43) begin n_fail++; $display("FAIL wide_latency got=%0d want=43", e); end
    n_checks++; if (w_out_data !== 64'h44c8fc20_b9dfa07a) begin n_fail++; $display("FAIL wide_enc_data got=%h want=44c8fc20b9dfa07a", w_out_data); end
    w_in_valid = 1'b1; w_in_mode = 1'b1; w_in_data = 64'h44c8fc20_b9dfa07a;
    @(negedge clk);
    w_in_valid = 1'b0;
    e = 0;
    while (!w_out_valid && e < 200) begin
      @(negedge clk);
      e++;
    end
    n_checks++; if (w_out_data !== 64'h656b696c_20646e75 || w_out_mode !== 1'b1) begin
      n_fail++; $display("FAIL wide_dec got=%h/%b want=656b696c20646e75/1", w_out_data, w_out_mode);
    end
  endtask

  task automatic test_reset_mid_expand();
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL expand_key_ready got=%b want=0", key_ready); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_key_valid got=%b want=0", key_valid); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_key_ready got=%b want=1", key_ready); end
    repeat (30) @(negedge clk);
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stays_empty got=%b want=0", key_valid); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_key_expand();
    test_encrypt();
    test_decrypt();
    test_back_to_back();
    test_key_lock();
    test_wide();
    test_reset_mid_expand();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
